// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              stall_o;
    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-ported memory
// Optional busy-timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              err_q;
    logic              timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q;

    // Counter rests at zero outside BUSY, so it is already clear on BUSY entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != BUSY_D && state_q != BUSY_I)) begin
            cnt_q <= '0;
        end else if (!bus.mem_ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Data wins: its instruction is older than the one being fetched.
                    if (bus.dm_req_i) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we_i;
                        mem_addr_q  <= bus.dm_addr_i;
                        mem_wdata_q <= bus.dm_wdata_i;
                    end else if (bus.if_req_i) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr_i;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (bus.mem_ack_i || timeout) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (state_q == BUSY_D) begin
                            dm_ack_q <= 1'b1;
                            if (!bus.mem_ack_i) begin
                                dm_rdata_q <= '0;
                            end else if (!mem_we_q) begin
                                dm_rdata_q <= bus.mem_rdata_i;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
                        end
                        if (!bus.mem_ack_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] mem_arr [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    acc_t        mem_log[$];
    int          wait_n = 0;
    int          wcnt   = 0;
    bit          hang   = 1'b0;
    logic        manual_ack   = 1'b0;
    logic [31:0] manual_rdata = 32'h0;
    logic [31:0] exp_dm_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory responder: acks after wait_n request cycles, or follows manual_ack when hung.
    always @(negedge clk) begin
        acc_t e;
        if (hang) begin
            bus.mem_ack_i   = manual_ack;
            bus.mem_rdata_i = manual_rdata;
            wcnt = 0;
        end else if (bus.mem_req_o === 1'b1) begin
            if (wcnt == wait_n) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = mem_rd(bus.mem_addr_o);
                e.we    = bus.mem_we_o;
                e.addr  = bus.mem_addr_o;
                e.wdata = bus.mem_wdata_o;
                mem_log.push_back(e);
                if (bus.mem_we_o) mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
            end else begin
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = $urandom;
            end
            wcnt++;
        end else begin
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = $urandom;
            wcnt = 0;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_dm_rdata = 32'h0;
    endtask

    task automatic run_trial(input bit do_if, input bit do_dm, input bit we,
                             input logic [31:0] if_a, input logic [31:0] dm_a,
                             input logic [31:0] wd, input int w, input bit scramble);
        int          if_c;
        int          dm_c;
        int          last;
        logic [31:0] exp_if;
        acc_t        e;
        acc_t        exp_q[$];
        wait_n = w;
        hang   = 1'b0;
        mem_log.delete();
        if_c   = -1;
        dm_c   = -1;
        exp_if = 32'h0;
        if (do_dm) begin
            dm_c = 2 + w;
            if (we) ref_mem[dm_a] = wd;
            else exp_dm_rdata = exp_rd(dm_a);
            e.we = we; e.addr = dm_a; e.wdata = wd;
            exp_q.push_back(e);
        end
        if (do_if) begin
            if_c   = do_dm ? 5 + 2 * w : 2 + w;
            exp_if = exp_rd(if_a);
            e.we = 1'b0; e.addr = if_a; e.wdata = 32'h0;
            exp_q.push_back(e);
        end
        last = ((if_c > dm_c) ? if_c : dm_c) + 1;

        @(posedge clk); #1;
        bus.if_req_i   = do_if;
        bus.if_addr_i  = if_a;
        bus.dm_req_i   = do_dm;
        bus.dm_we_i    = we;
        bus.dm_addr_i  = dm_a;
        bus.dm_wdata_i = wd;

        for (int c = 0; c <= last; c++) begin
            bit   in1;
            bit   in2;
            acc_t cur;
            @(negedge clk);
            in1 = (c >= 1) && (c <= 1 + w);
            in2 = do_if && do_dm && (c >= 4 + w) && (c <= 4 + 2 * w);
            chk("mem_req_o", bus.mem_req_o, in1 || in2);
            if (in1 || in2) begin
                cur = in1 ? exp_q[0] : exp_q[1];
                chk("mem_addr_o", bus.mem_addr_o, cur.addr);
                chk("mem_we_o", bus.mem_we_o, cur.we);
                if (cur.we) chk("mem_wdata_o", bus.mem_wdata_o, cur.wdata);
            end
            chk("stall_o", bus.stall_o, (do_if && c < if_c) || (do_dm && c < dm_c));
            chk("if_ack_o", bus.if_ack_o, c == if_c);
            chk("dm_ack_o", bus.dm_ack_o, c == dm_c);
            if (c == if_c) chk("if_rdata_o", bus.if_rdata_o, exp_if);
            if (c == dm_c) chk("dm_rdata_o", bus.dm_rdata_o, exp_dm_rdata);
            @(posedge clk); #1;
            if (c == if_c) begin
                bus.if_req_i  = 1'b0;
                bus.if_addr_i = $urandom;
            end
            if (c == dm_c) begin
                bus.dm_req_i   = 1'b0;
                bus.dm_addr_i  = $urandom;
                bus.dm_wdata_i = $urandom;
            end else if (scramble && c < dm_c) begin
                bus.dm_addr_i  = $urandom;
                bus.dm_wdata_i = $urandom;
            end
        end

        chk("mem_access_count", mem_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mem_log.size(); i++) begin
            chk("mem_order_addr", mem_log[i].addr, exp_q[i].addr);
            chk("mem_order_we", mem_log[i].we, exp_q[i].we);
            if (exp_q[i].we) chk("mem_order_wdata", mem_log[i].wdata, exp_q[i].wdata);
        end
        chk("dm_rdata_hold", bus.dm_rdata_o, exp_dm_rdata);
        chk("err_o_idle", bus.err_o, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'h0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = 32'h0;
        bus.dm_wdata_i = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_mem_we", bus.mem_we_o, 1'b0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_if_ack", bus.if_ack_o, 1'b0);
        chk("rst_dm_ack", bus.dm_ack_o, 1'b0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_stall", bus.stall_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: zero-wait fetch, slow data read with address churn, write+fetch collision.
        mem_arr[32'h10] = 32'h2002_0005; ref_mem[32'h10] = 32'h2002_0005;
        run_trial(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 1'b0);
        mem_arr[32'h30] = 32'h1234_5678; ref_mem[32'h30] = 32'h1234_5678;
        run_trial(1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 32'h0, 4, 1'b1);
        run_trial(1'b1, 1'b1, 1'b1, 32'h14, 32'h40, 32'hCAFE_F00D, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int          mode;
            logic [31:0] ia;
            logic [31:0] da;
            mode = $urandom_range(0, 2);
            ia   = 32'($urandom_range(0, 15)) << 2;
            da   = 32'($urandom_range(0, 15)) << 2;
            run_trial(mode != 1, mode != 0, 1'($urandom_range(0, 1)), ia, da,
                      $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        hang       = 1'b1;
        manual_ack = 1'b0;
        @(posedge clk); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h20;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk("to_mem_req", bus.mem_req_o, (c >= 1) && (c <= 8));
            chk("to_if_ack", bus.if_ack_o, c == 9);
            chk("to_err", bus.err_o, c >= 9);
            if (c == 9) chk("to_if_rdata", bus.if_rdata_o, 32'h0);
            @(posedge clk); #1;
            if (c == 9) bus.if_req_i = 1'b0;
        end
`else
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            chk("hang_mem_req", bus.mem_req_o, c >= 1);
            chk("hang_if_ack", bus.if_ack_o, 1'b0);
            chk("hang_err", bus.err_o, 1'b0);
            @(posedge clk); #1;
        end
`endif

        // Reset in the middle of a hung data write, then a stray memory ack.
        do_reset();
        run_trial(1'b0, 1'b1, 1'b0, 32'h0, 32'h50, 32'h0, 1, 1'b0);
        hang         = 1'b1;
        manual_ack   = 1'b0;
        manual_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h44;
        bus.dm_wdata_i = 32'h5555_AAAA;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk("mid_mem_req", bus.mem_req_o, c >= 1);
            @(posedge clk); #1;
        end
        rst          = 1'b1;
        bus.dm_req_i = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        manual_ack = 1'b1;
        @(negedge clk);
        chk("mrst_mem_req", bus.mem_req_o, 1'b0);
        chk("mrst_mem_we", bus.mem_we_o, 1'b0);
        chk("mrst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("mrst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("mrst_dm_rdata", bus.dm_rdata_o, 32'h0);
        chk("mrst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("mrst_err", bus.err_o, 1'b0);
        @(posedge clk); #1;
        manual_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_dm_ack", bus.dm_ack_o, 1'b0);
            chk("stray_if_ack", bus.if_ack_o, 1'b0);
            chk("stray_mem_req", bus.mem_req_o, 1'b0);
            chk("stray_dm_rdata", bus.dm_rdata_o, 32'h0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipelined CPU. Each requester holds a request until it gets a one-cycle acknowledge. The block serialises accesses through a small FSM and drives a global pipeline stall while any request is outstanding. It sits between the IF/MEM stages and the memory model, replacing the separate instruction and data memory ports.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in BUSY before abort (used only with the timeout feature)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch read request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i high
- if_rdata_o  out  DATA_W  fetch data; valid while if_ack_o high
- if_ack_o  out  1  one-cycle fetch completion pulse
- dm_req_i  in  1  data request; held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  load data; valid while dm_ack_o high
- dm_ack_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data; sampled with mem_ack_i
- mem_ack_i  in  1  memory completion; may be asserted in the first request cycle
- stall_o  out  1  pipeline stall, combinational
- err_o  out  1  sticky timeout error

## Operation
- FSM states:
  - IDLE: no memory access in progress.
  - BUSY_D: data access owns the memory.
  - BUSY_I: fetch access owns the memory.
  - RESP: completion cycle.
- IDLE:
  - dm_req_i high: go to BUSY_D. Latch dm_addr_i, dm_we_i, dm_wdata_i into mem_addr_o, mem_we_o, mem_wdata_o.
  - Otherwise, if_req_i high: go to BUSY_I. Latch if_addr_i, set mem_we_o=0.
  - Fixed priority: data beats fetch. The older instruction must complete first, and fetch cannot starve because the pipeline is stalled.
- BUSY_x:
  - mem_req_o=1.
  - On mem_ack_i=1, go to RESP and record the owner.
  - For a data read, capture mem_rdata_i into dm_rdata_o. For a fetch, capture into if_rdata_o.
  - For a write, dm_rdata_o keeps its previous value.
- RESP:
  - Owner's ack_o=1 for exactly this cycle; mem_req_o=0; then go to IDLE unconditionally.
  - The extra IDLE cycle gives the requester time to drop or change its request.
- mem_ack_i is ignored in IDLE and RESP.
- Requests are not re-sampled outside IDLE. Address or data changes during BUSY have no effect.
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- Reset, including mid-transaction:
  - State goes to IDLE.
  - mem_req_o, mem_we_o, if_ack_o, dm_ack_o and err_o go to 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o and dm_rdata_o go to 0.
  - A late mem_ack_i arriving after reset is ignored because the FSM is in IDLE.

## Timing
- All outputs are registered except stall_o.
- Zero-wait memory (mem_ack_i in the first BUSY cycle):
  - req seen at edge 0; mem_req_o high in cycle 1; ack_o high in cycle 2; IDLE in cycle 3.
  - Minimum 3 cycles per access.
- N-cycle memory wait adds N cycles.
- Both requests present at edge 0: data ack in cycle 2. Fetch is granted at edge 3 and acked in cycle 5 with zero-wait memory.
- Back-to-back requests from the same requester: the new request is granted from IDLE at the earliest edge after the ack cycle.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter, sized to hold TIMEOUT, clears on entry to BUSY and increments each BUSY cycle without mem_ack_i.
  - When the count reaches TIMEOUT, go to RESP: drop mem_req_o, pulse the owner's ack_o with rdata_o=0, and set err_o.
  - err_o stays high until rst_i.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - err_o is tied to 0.

## Test plan
- Reset then if_req_i=1, if_addr_i=0x0000_0010, mem_ack_i same cycle as mem_req_o with rdata 0x2002_0005 -> mem_addr_o=0x10, mem_we_o=0, if_ack_o pulses exactly one cycle in cycle 2 with if_rdata_o=0x2002_0005, stall_o high cycles 0-1.
- if_req_i and dm_req_i (we=1, addr 0x40, wdata 0xCAFE_F00D) together -> memory sees the write first (mem_we_o=1, addr 0x40), dm_ack_o in cycle 2, then a fetch read; if_ack_o in cycle 5; dm_rdata_o unchanged.
- Data read with 4-cycle memory wait, mem_rdata_i=0x1234_5678 -> mem_req_o high 5 cycles, dm_ack_o one cycle later with 0x1234_5678; changes to dm_addr_i during BUSY do not alter mem_addr_o.
- rst_i asserted during BUSY_D, then mem_ack_i pulses -> all outputs return to reset values next cycle; no ack_o is generated from the stray mem_ack_i.
- With ARB_TIMEOUT_EN and TIMEOUT=8, memory never acks -> mem_req_o drops after 8 BUSY cycles, owner ack_o pulses with rdata 0, err_o=1 until reset. Without the macro, mem_req_o stays high and err_o=0 for 1000 cycles.
